// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter.
// Optional perf counters in the top are enabled by IMEM_ARB_PERF_EN.
package imem_arb_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, LOCKED} arb_state_e;
    typedef enum logic [1:0] {NONE, OWN_F, OWN_L} owner_e;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the loader has been denied.
// at_max forces a loader grant so it cannot be starved by fetch.
module imem_arb_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [STARVE_W-1:0] cnt;

    assign at_max = (cnt == STARVE_W'(MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates one single-port instruction memory between fetch (priority) and the loader.
// Defining IMEM_ARB_PERF_EN adds perf_conflict / perf_fstall cycle counters.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              flush,
    output logic              stall_f,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
`ifdef IMEM_ARB_PERF_EN
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_fstall,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        stateQ, stateD;
    owner_e            ownerQ, ownerD;
    logic              atMax, lockHold, grantF, grantL;
    logic [DATA_W-1:0] fRdataQ, lRdataQ;

    imem_arb_starve_ctr #(.MAX(STARVE_MAX)) uStarve (
        .clk    (clk),
        .rst    (rst),
        .inc    (l_req && !grantL),
        .clr    (grantL || !l_req),
        .at_max (atMax)
    );

    // Grants are gated by reset so every output drops the moment reset asserts.
    assign lockHold = (stateQ == LOCKED) && l_req;
    assign grantL   = rst && l_req && (lockHold || atMax || !f_req);
    assign grantF   = rst && f_req && !grantL;

    assign stall_f   = rst && f_req && !grantF;
    assign l_gnt     = grantL;
    assign mem_en    = grantF || grantL;
    assign mem_we    = grantL && l_we;
    assign mem_addr  = grantL ? l_addr  : (grantF ? f_addr : '0);
    assign mem_wdata = grantL ? l_wdata : '0;

    always_comb begin
        stateD = IDLE;
        ownerD = NONE;
        if (grantL) begin
            stateD = l_lock ? LOCKED : LOAD;
            ownerD = l_we ? NONE : OWN_L;
        end else if (grantF) begin
            stateD = FETCH;
            ownerD = flush ? NONE : OWN_F;
        end
    end

    // Read data is passed straight through in the response cycle and held afterwards.
    assign f_rvalid = (ownerQ == OWN_F);
    assign l_rvalid = (ownerQ == OWN_L);
    assign f_rdata  = f_rvalid ? mem_rdata : fRdataQ;
    assign l_rdata  = l_rvalid ? mem_rdata : lRdataQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ  <= IDLE;
            ownerQ  <= NONE;
            fRdataQ <= '0;
            lRdataQ <= '0;
        end else begin
            stateQ <= stateD;
            ownerQ <= ownerD;
            if (f_rvalid) fRdataQ <= mem_rdata;
            if (l_rvalid) lRdataQ <= mem_rdata;
        end
    end

`ifdef IMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict <= '0;
            perf_fstall   <= '0;
        end else begin
            if (f_req && l_req) perf_conflict <= perf_conflict + 32'd1;
            if (stall_f)        perf_fstall   <= perf_fstall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a simple 64-word synchronous memory model.
// Unwritten words read back as 0xA0000000 + word index.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, flush, l_req, l_we, l_lock;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        stall_f, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we;
    logic [31:0] f_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_conflict, perf_fstall;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] memArr [0:63];

    always #5 clk = ~clk;

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .flush     (flush),
        .stall_f   (stall_f),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_lock    (l_lock),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
`ifdef IMEM_ARB_PERF_EN
        .perf_conflict (perf_conflict),
        .perf_fstall   (perf_fstall),
`endif
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) memArr[i] <= 32'hA000_0000 + 32'(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) memArr[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= memArr[mem_addr[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then applied for that cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; f_req = 0; flush = 0; l_req = 0; l_we = 0; l_lock = 0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        #12;
        chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst_l_rvalid", 32'(l_rvalid), 32'd0);
        chk("rst_mem_en",   32'(mem_en),   32'd0);
        chk("rst_f_rdata",  f_rdata,       32'd0);
        cyc();
        rst = 1'b1;

        // 1: lone fetch
        cyc();
        f_req = 1; f_addr = 32'h10;
        #1;
        chk("t1_mem_en",   32'(mem_en),  32'd1);
        chk("t1_mem_addr", mem_addr,     32'h10);
        chk("t1_stall_f",  32'(stall_f), 32'd0);
        chk("t1_l_gnt",    32'(l_gnt),   32'd0);
        cyc();
        f_req = 0;
        #1;
        chk("t1_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("t1_f_rdata",  f_rdata,       32'hA000_0004);
        chk("t1_l_rvalid", 32'(l_rvalid), 32'd0);

        // 2: contention, loader forced in on the 5th cycle
        cyc();
        f_req = 1; f_addr = 32'h14; l_req = 1; l_addr = 32'h30;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_f_wins_stall", 32'(stall_f), 32'd0);
            chk("t2_f_wins_lgnt",  32'(l_gnt),   32'd0);
            chk("t2_f_wins_addr",  mem_addr,     32'h14);
            cyc();
        end
        #1;
        chk("t2_starve_lgnt",  32'(l_gnt),   32'd1);
        chk("t2_starve_stall", 32'(stall_f), 32'd1);
        chk("t2_starve_addr",  mem_addr,     32'h30);
        cyc();
        #1;
        chk("t2_after_lgnt",    32'(l_gnt),    32'd0);
        chk("t2_after_stall",   32'(stall_f),  32'd0);
        chk("t2_l_rvalid",      32'(l_rvalid), 32'd1);
        chk("t2_l_rdata",       l_rdata,       32'hA000_000C);
        chk("t2_f_rvalid_none", 32'(f_rvalid), 32'd0);
        cyc();
        f_req = 0; l_req = 0;
        #1;
        chk("t2_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("t2_f_rdata",  f_rdata,       32'hA000_0005);

        // 3: loader write then read back
        cyc();
        l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t3_mem_we",    32'(mem_we), 32'd1);
        chk("t3_mem_wdata", mem_wdata,   32'hDEAD_BEEF);
        chk("t3_mem_addr",  mem_addr,    32'h20);
        chk("t3_l_gnt",     32'(l_gnt),  32'd1);
        cyc();
        l_we = 0;
        #1;
        chk("t3_no_wr_rvalid", 32'(l_rvalid), 32'd0);
        chk("t3_rd_mem_we",    32'(mem_we),   32'd0);
        cyc();
        l_req = 0;
        #1;
        chk("t3_l_rvalid", 32'(l_rvalid), 32'd1);
        chk("t3_l_rdata",  l_rdata,       32'hDEAD_BEEF);

        // 4: locked burst holds fetch off
        cyc();
        l_req = 1; l_lock = 1; l_addr = 32'h24;
        #1;
        chk("t4_first_lgnt", 32'(l_gnt), 32'd1);
        cyc();
        f_req = 1; f_addr = 32'h18;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_lock_stall", 32'(stall_f), 32'd1);
            chk("t4_lock_lgnt",  32'(l_gnt),   32'd1);
            cyc();
        end
        l_req = 0; l_lock = 0;
        #1;
        chk("t4_f_regain_stall", 32'(stall_f),  32'd0);
        chk("t4_f_regain_addr",  mem_addr,      32'h18);
        chk("t4_l_rvalid",       32'(l_rvalid), 32'd1);
        chk("t4_l_rdata",        l_rdata,       32'hA000_0009);
        cyc();
        f_req = 0;
        #1;
        chk("t4_f_rdata", f_rdata, 32'hA000_0006);

        // 5: flush kills the in-flight fetch response
        cyc();
        f_req = 1; f_addr = 32'h1C; flush = 1;
        #1;
        chk("t5_flush_grant", 32'(mem_en), 32'd1);
        cyc();
        flush = 0; f_addr = 32'h08;
        #1;
        chk("t5_killed_rvalid", 32'(f_rvalid), 32'd0);
        cyc();
        f_req = 0;
        #1;
        chk("t5_next_rvalid", 32'(f_rvalid), 32'd1);
        chk("t5_next_rdata",  f_rdata,       32'hA000_0002);

        // 6: reset while locked with a read in flight
        cyc();
        l_req = 1; l_lock = 1; l_addr = 32'h28;
        cyc();
        f_req = 1;
        #1;
        chk("t6_locked_lgnt", 32'(l_gnt), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_lgnt",     32'(l_gnt),    32'd0);
        chk("t6_rst_mem_en",   32'(mem_en),   32'd0);
        chk("t6_rst_stall",    32'(stall_f),  32'd0);
        chk("t6_rst_l_rvalid", 32'(l_rvalid), 32'd0);
        chk("t6_rst_l_rdata",  l_rdata,       32'd0);
        f_req = 0; l_req = 0; l_lock = 0;
        cyc();
        rst = 1'b1;
        cyc();
        #1;
        chk("t6_post_l_rvalid", 32'(l_rvalid), 32'd0);
        chk("t6_post_f_rvalid", 32'(f_rvalid), 32'd0);
        l_req = 1;
        #1;
        chk("t6_lock_dropped_lgnt", 32'(l_gnt), 32'd1);
        f_req = 1;
        #1;
        chk("t6_lock_dropped_f", 32'(stall_f), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
